// File: rtl/fse_filter_slicer.sv
// fse_filter_slicer: T/2 complex FIR equalizer with 16-QAM slicer and LMS error/enable generation
// Ports: clk, i_reset (sync, active-high); i_valid/i_data_I/i_data_Q feed the T/2 sample stream;
// i_taps_I/i_taps_Q are the packed taps from the LMS stage (tap m at [(m+1)*NBT_TAPS-1 : m*NBT_TAPS]).
// o_y_*/o_sym_*/o_err_* carry output, decision and error, all qualified by o_valid.
// o_en_taps is the LMS tap-update enable; o_en_shtr/o_is_data_* feed the LMS shifter 3 cycles late.
module fse_filter_slicer #(
  parameter int NUM_TAPS = 11,
  parameter int NBT_IN = 8,
  parameter int NBF_IN = 7,
  parameter int NBT_TAPS = 28,
  parameter int NBF_TAPS = 25,
  parameter int NBT_ERR = 12,
  parameter int NBF_ERR = 9,
  parameter logic signed [NBT_ERR-1:0] LVL = 12'sd128
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic                         i_valid,
  input  logic [NBT_IN-1:0]            i_data_I,
  input  logic [NBT_IN-1:0]            i_data_Q,
  input  logic [NUM_TAPS*NBT_TAPS-1:0] i_taps_I,
  input  logic [NUM_TAPS*NBT_TAPS-1:0] i_taps_Q,
  output logic [NBT_ERR-1:0]           o_y_I,
  output logic [NBT_ERR-1:0]           o_y_Q,
  output logic [NBT_ERR-1:0]           o_sym_I,
  output logic [NBT_ERR-1:0]           o_sym_Q,
  output logic [NBT_ERR-1:0]           o_err_I,
  output logic [NBT_ERR-1:0]           o_err_Q,
  output logic                         o_valid,
  output logic                         o_en_taps,
  output logic                         o_en_shtr,
  output logic [NBT_IN-1:0]            o_is_data_I,
  output logic [NBT_IN-1:0]            o_is_data_Q
);
  localparam int NBP = NBT_TAPS + NBT_IN + 1;
  localparam int NBS = NBP + $clog2(NUM_TAPS);
  localparam int DROP = NBF_TAPS + NBF_IN - NBF_ERR;
  localparam int NBH = NBS - DROP;
  localparam logic signed [NBT_ERR-1:0] LVL2 = NBT_ERR'(2 * LVL);
  localparam logic signed [NBT_ERR-1:0] LVL3 = NBT_ERR'(3 * LVL);
  localparam logic signed [NBT_ERR-1:0] YMAX = {1'b0, {(NBT_ERR-1){1'b1}}};
  localparam logic signed [NBT_ERR-1:0] YMIN = ~YMAX;

  function automatic logic signed [NBT_ERR-1:0] sat(input logic signed [NBH-1:0] v);
    return v > NBH'(YMAX) ? YMAX : v < NBH'(YMIN) ? YMIN : v[NBT_ERR-1:0];
  endfunction

  function automatic logic signed [NBT_ERR-1:0] slice(input logic signed [NBT_ERR-1:0] y);
    return y >= LVL2 ? LVL3 : !y[NBT_ERR-1] ? LVL : y >= -LVL2 ? -LVL : -LVL3;
  endfunction

  logic signed [NBT_TAPS-1:0] t_i [NUM_TAPS];
  logic signed [NBT_TAPS-1:0] t_q [NUM_TAPS];
  logic signed [NBT_IN-1:0] x_i [NUM_TAPS];
  logic signed [NBT_IN-1:0] x_q [NUM_TAPS];
  logic signed [NBP-1:0] p_i [NUM_TAPS];
  logic signed [NBP-1:0] p_q [NUM_TAPS];
  logic signed [NBS-1:0] s_i, s_q, sum_i, sum_q;
  logic signed [NBT_ERR-1:0] y_i, y_q, sym_i, sym_q, err_i, err_q;
  logic phase;
  logic [2:0] sym_pipe;
  logic [1:0] fwd_pipe;
  logic [NBT_IN-1:0] d1_i, d1_q, d2_i, d2_q;

  for (genvar m = 0; m < NUM_TAPS; m++) begin : g_taps
    assign t_i[m] = i_taps_I[m*NBT_TAPS +: NBT_TAPS];
    assign t_q[m] = i_taps_Q[m*NBT_TAPS +: NBT_TAPS];
  end

  always_comb begin
    sum_i = '0;
    sum_q = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      sum_i = sum_i + NBS'(p_i[k]);
      sum_q = sum_q + NBS'(p_q[k]);
    end
    y_i = sat(s_i[NBS-1:DROP]);
    y_q = sat(s_q[NBS-1:DROP]);
    sym_i = slice(y_i);
    sym_q = slice(y_q);
    err_i = sat(NBH'(y_i) - NBH'(sym_i));
    err_q = sat(NBH'(y_q) - NBH'(sym_q));
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_i[k] <= '0;
        x_q[k] <= '0;
        p_i[k] <= '0;
        p_q[k] <= '0;
      end
      phase <= 1'b0;
      sym_pipe <= '0;
      fwd_pipe <= '0;
      s_i <= '0;
      s_q <= '0;
      d1_i <= '0;
      d1_q <= '0;
      d2_i <= '0;
      d2_q <= '0;
      o_y_I <= '0;
      o_y_Q <= '0;
      o_sym_I <= '0;
      o_sym_Q <= '0;
      o_err_I <= '0;
      o_err_Q <= '0;
      o_valid <= 1'b0;
      o_en_taps <= 1'b0;
      o_en_shtr <= 1'b0;
      o_is_data_I <= '0;
      o_is_data_Q <= '0;
    end else begin
      if (i_valid) begin
        x_i[0] <= i_data_I;
        x_q[0] <= i_data_Q;
        for (int k = 1; k < NUM_TAPS; k++) begin
          x_i[k] <= x_i[k-1];
          x_q[k] <= x_q[k-1];
        end
        phase <= ~phase;
        d1_i <= i_data_I;
        d1_q <= i_data_Q;
      end
      for (int k = 0; k < NUM_TAPS; k++) begin
        p_i[k] <= NBP'(t_i[k]) * NBP'(x_i[k]) - NBP'(t_q[k]) * NBP'(x_q[k]);
        p_q[k] <= NBP'(t_i[k]) * NBP'(x_q[k]) + NBP'(t_q[k]) * NBP'(x_i[k]);
      end
      s_i <= sum_i;
      s_q <= sum_q;
      sym_pipe <= {sym_pipe[1:0], i_valid & phase};
      fwd_pipe <= {fwd_pipe[0], i_valid};
      d2_i <= d1_i;
      d2_q <= d1_q;
      o_is_data_I <= d2_i;
      o_is_data_Q <= d2_q;
      o_en_shtr <= fwd_pipe[1];
      o_valid <= sym_pipe[2];
      o_en_taps <= sym_pipe[2];
      if (sym_pipe[2]) begin
        o_y_I <= y_i;
        o_y_Q <= y_q;
        o_sym_I <= sym_i;
        o_sym_Q <= sym_q;
        o_err_I <= err_i;
        o_err_Q <= err_q;
      end
    end
  end
endmodule

// File: tb/tb_fse_filter_slicer.sv
// tb_fse_filter_slicer: directed stimulus with a scoreboard of expected outputs and forwarded samples
module tb_fse_filter_slicer;
  localparam int N = 11;
  localparam int TW = 28;

  logic clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_valid = 1'b0;
  logic signed [7:0] di = '0, dq = '0;
  logic [N*TW-1:0] ti = '0, tq = '0;
  logic signed [11:0] y_i, y_q, s_i, s_q, e_i, e_q;
  logic signed [7:0] fd_i, fd_q;
  logic ov, et, es;
  int n_assert = 0, n_fail = 0, cyc = 0;

  typedef struct {
    int c;
    logic signed [11:0] yi, yq, si, sq, ei, eq;
  } out_t;
  typedef struct {
    int c;
    logic signed [7:0] i, q;
  } fw_t;
  out_t oq[$];
  fw_t fq[$];
  logic signed [7:0] wi[N], wq[N];
  bit ph;

  fse_filter_slicer dut (
    .clk(clk), .i_reset(i_reset), .i_valid(i_valid),
    .i_data_I(di), .i_data_Q(dq), .i_taps_I(ti), .i_taps_Q(tq),
    .o_y_I(y_i), .o_y_Q(y_q), .o_sym_I(s_i), .o_sym_Q(s_q),
    .o_err_I(e_i), .o_err_Q(e_q), .o_valid(ov), .o_en_taps(et),
    .o_en_shtr(es), .o_is_data_I(fd_i), .o_is_data_Q(fd_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [11:0] sat(input longint v);
    return v > 2047 ? 12'sd2047 : v < -2048 ? -12'sd2048 : v[11:0];
  endfunction

  function automatic logic signed [11:0] slc(input logic signed [11:0] y);
    return y >= 256 ? 12'sd384 : y >= 0 ? 12'sd128 : y >= -256 ? -12'sd128 : -12'sd384;
  endfunction

  function automatic longint tap(input logic [N*TW-1:0] t, input int k);
    return longint'($signed(t[k*TW +: TW]));
  endfunction

  always @(negedge clk) begin
    if (i_reset) begin
      ph = 0;
      oq.delete();
      fq.delete();
      for (int k = 0; k < N; k++) begin
        wi[k] = '0;
        wq[k] = '0;
      end
    end else begin
      if (es) begin
        n_assert++;
        assert (fq.size() > 0) else begin
          n_fail++;
          $error("FAIL shtr_unexpected: observed pulse at cycle %0d expected none", cyc);
        end
        if (fq.size() > 0) begin
          fw_t f;
          f = fq.pop_front();
          chk("shtr_cycle", cyc, f.c);
          chk("is_data_I", fd_i, f.i);
          chk("is_data_Q", fd_q, f.q);
        end
      end
      if (ov || et) begin
        chk("en_taps_eq_valid", et, ov);
        n_assert++;
        assert (oq.size() > 0) else begin
          n_fail++;
          $error("FAIL valid_unexpected: observed pulse at cycle %0d expected none", cyc);
        end
        if (oq.size() > 0) begin
          out_t o;
          o = oq.pop_front();
          chk("valid_cycle", cyc, o.c);
          chk("y_I", y_i, o.yi);
          chk("y_Q", y_q, o.yq);
          chk("sym_I", s_i, o.si);
          chk("sym_Q", s_q, o.sq);
          chk("err_I", e_i, o.ei);
          chk("err_Q", e_q, o.eq);
        end
      end
      if (i_valid) begin
        for (int k = N - 1; k > 0; k--) begin
          wi[k] = wi[k-1];
          wq[k] = wq[k-1];
        end
        wi[0] = di;
        wq[0] = dq;
        fq.push_back('{cyc + 3, di, dq});
        if (ph) begin
          longint ai, aq;
          logic signed [11:0] yi, yq, si, sq;
          ai = 0;
          aq = 0;
          for (int k = 0; k < N; k++) begin
            ai += tap(ti, k) * wi[k] - tap(tq, k) * wq[k];
            aq += tap(ti, k) * wq[k] + tap(tq, k) * wi[k];
          end
          yi = sat(ai >>> 23);
          yq = sat(aq >>> 23);
          si = slc(yi);
          sq = slc(yq);
          oq.push_back('{cyc + 4, yi, yq, si, sq, sat(longint'(yi) - longint'(si)), sat(longint'(yq) - longint'(sq))});
        end
        ph = ~ph;
      end
    end
  end

  task automatic send(input logic signed [7:0] a, input logic signed [7:0] b);
    @(posedge clk);
    #1;
    di = a;
    dq = b;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic fill(input logic signed [7:0] a, input logic signed [7:0] b);
    for (int i = 0; i < 12; i++) send(a, b);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (oq.size() > 0 || fq.size() > 0); i++) @(posedge clk);
    n_assert++;
    assert (oq.size() == 0 && fq.size() == 0) else begin
      n_fail++;
      $error("FAIL drain_timeout: observed %0d/%0d pending expected 0/0", oq.size(), fq.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int xs[4] = '{0, 64, -64, -64};
    int ds[4] = '{0, -1, 0, 1};
    int ye[4] = '{0, 255, -256, -257};
    int se[4] = '{128, 128, -128, -384};
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", ov, 0);
    chk("rst_en_shtr", es, 0);
    chk("rst_y_I", y_i, 0);
    chk("rst_err_Q", e_q, 0);
    chk("rst_is_data", fd_i, 0);
    @(posedge clk);
    #1;

    ti = '0;
    ti[5*TW +: TW] = 28'h2000000;
    fill(8'sh40, 8'sh00);
    drain();
    chk("t1_y_I", y_i, 256);
    chk("t1_sym_I", s_i, 384);
    chk("t1_err_I", e_i, -128);
    chk("t1_y_Q", y_q, 0);
    chk("t1_sym_Q", s_q, 128);
    chk("t1_err_Q", e_q, -128);

    for (int c = 0; c < 4; c++) begin
      ti = '0;
      ti[5*TW +: TW] = 28'h2000000;
      ti[4*TW +: TW] = TW'(ds[c]);
      fill(8'(xs[c]), 8'sh00);
      drain();
      chk("t3_y_I", y_i, ye[c]);
      chk("t3_sym_I", s_i, se[c]);
    end

    for (int k = 0; k < N; k++) ti[k*TW +: TW] = 28'h7FFFFFF;
    fill(-8'sd128, 8'sh00);
    drain();
    chk("t4_neg_y_I", y_i, -2048);
    chk("t4_neg_sym_I", s_i, -384);
    chk("t4_neg_err_I", e_i, -1664);
    fill(8'sd127, 8'sh00);
    drain();
    chk("t4_pos_y_I", y_i, 2047);
    chk("t4_pos_err_I", e_i, 1663);

    ti = '0;
    tq = '0;
    tq[5*TW +: TW] = 28'h2000000;
    fill(8'sh40, 8'sh00);
    drain();
    chk("t6_y_Q", y_q, 256);
    chk("t6_y_I", y_i, 0);
    fill(8'sh00, 8'sh40);
    drain();
    chk("t6_neg_y_I", y_i, -256);
    chk("t6_neg_y_Q", y_q, 0);

    tq = '0;
    ti = '0;
    ti[5*TW +: TW] = 28'h2000000;
    send(8'sh40, 8'sh00);
    @(posedge clk);
    #1;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_valid", ov, 0);
      chk("t5_en_taps", et, 0);
      chk("t5_en_shtr", es, 0);
    end
    chk("t5_y_I", y_i, 0);
    chk("t5_sym_I", s_i, 0);
    chk("t5_err_Q", e_q, 0);
    send(8'sh40, 8'sh00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_phase0_valid", ov, 0);
    end
    send(8'sh40, 8'sh00);
    drain();
    chk("t5_phase1_sym_I", s_i, 128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
